// File: rtl/mc_bridge_pkg.sv
// Shared definitions for the MCU memory-controller bus bridge.
// Holds bus width defaults, register map addresses, error counter width and
// the bridge FSM state encoding. Imported by mc_bridge_if and mc_bridge.
package mc_bridge_pkg;

    localparam int unsigned MC_DATA_WIDTH_DEF = 16;
    localparam int unsigned MC_ADD_WIDTH_DEF  = 6;
    localparam int unsigned NUM_REGS_DEF      = 32;
    localparam int unsigned ERR_WIDTH         = 8;

    // Register map entries used by downstream peripherals
    localparam logic [MC_ADD_WIDTH_DEF-1:0] REG_PWM_ON  = 6'h19;
    localparam logic [MC_ADD_WIDTH_DEF-1:0] REG_PWM_OFF = 6'h1A;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        WRITE     = 3'd2,
        RD_LOAD   = 3'd3,
        RD_DRIVE  = 3'd4
    } state_t;

endpackage

// File: rtl/mc_bridge_if.sv
// MCU parallel bus as seen at the FPGA pins.
//   master: MCU side, drives mc_ce/mc_we/mc_oe (active low), mc_add, mc_din
//   slave : bridge side, drives mc_dout and its tristate enable mc_dout_oe
interface mc_bridge_if
    import mc_bridge_pkg::*;
#(
    parameter int unsigned DW = MC_DATA_WIDTH_DEF,
    parameter int unsigned AW = MC_ADD_WIDTH_DEF
) ();

    logic          mc_ce;
    logic          mc_we;
    logic          mc_oe;
    logic [AW-1:0] mc_add;
    logic [DW-1:0] mc_din;
    logic [DW-1:0] mc_dout;
    logic          mc_dout_oe;

    modport master (
        output mc_ce, mc_we, mc_oe, mc_add, mc_din,
        input  mc_dout, mc_dout_oe
    );

    modport slave (
        input  mc_ce, mc_we, mc_oe, mc_add, mc_din,
        output mc_dout, mc_dout_oe
    );

endinterface

// File: rtl/mc_bridge_sync_ff.sv
// Parameterised-width 2-flop synchronizer (sync_ff).
// Ports: clock, reset (sync, active high), d (async in), q (synchronized out).
// RST_VAL sets the reset value (strobes use all-ones = inactive).
// FILTER adds a 2-sample glitch filter: an output bit follows only when both
// synchronizer stages agree, costing one extra clock.
// DELAY adds a plain register stage so data stays aligned with filtered strobes.
module mc_bridge_sync_ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               FILTER  = 1'b0,
    parameter bit               DELAY   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Two-stage synchronizer
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    generate
        if (FILTER) begin : g_filter
            logic [WIDTH-1:0] filt;
            // Stage 1 has had a full clock to settle when read here, same as stage 2's input
            always_ff @(posedge clock) begin
                if (reset) begin
                    filt <= RST_VAL;
                end else begin
                    filt <= ((s1 ~^ s2) & s2) | ((s1 ^ s2) & filt);
                end
            end
            assign q = filt;
        end else if (DELAY) begin : g_delay
            logic [WIDTH-1:0] dly;
            always_ff @(posedge clock) begin
                if (reset) begin
                    dly <= RST_VAL;
                end else begin
                    dly <= s2;
                end
            end
            assign q = dly;
        end else begin : g_plain
            assign q = s2;
        end
    endgenerate

endmodule

// File: rtl/mc_bridge.sv
// MCU memory-controller bus bridge.
// Synchronizes the async active-low ce/we/oe strobes and add/din into the
// clock domain, holds a NUM_REGS x MC_DATA_WIDTH register file, and emits
// single-cycle write/read events for downstream peripherals.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   bus (slave)          MCU pins: mc_ce/mc_we/mc_oe/mc_add/mc_din in, mc_dout/mc_dout_oe out
//   reg_q                flat register file, reg k at [k*W +: W]
//   wr_stb/wr_add/wr_data  one-cycle pulse per committed write (any address)
//   rd_stb/rd_add        one-cycle pulse for reads at addresses >= NUM_REGS
//   rd_data              external read data, sampled the cycle after rd_stb
//   err_cnt              saturating protocol-error count
// Build option: define MC_BRIDGE_FILTER_EN to glitch-filter ce/we/oe (+1 clock latency).
module mc_bridge
    import mc_bridge_pkg::*;
#(
    parameter int unsigned MC_DATA_WIDTH = MC_DATA_WIDTH_DEF,
    parameter int unsigned MC_ADD_WIDTH  = MC_ADD_WIDTH_DEF,
    parameter int unsigned NUM_REGS      = NUM_REGS_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    mc_bridge_if.slave                        bus,
    output logic [NUM_REGS*MC_DATA_WIDTH-1:0] reg_q,
    output logic                              wr_stb,
    output logic [MC_ADD_WIDTH-1:0]           wr_add,
    output logic [MC_DATA_WIDTH-1:0]          wr_data,
    output logic                              rd_stb,
    output logic [MC_ADD_WIDTH-1:0]           rd_add,
    input  logic [MC_DATA_WIDTH-1:0]          rd_data,
    output logic [ERR_WIDTH-1:0]              err_cnt
);

`ifdef MC_BRIDGE_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned SETTLE_W   = 2;
    localparam int unsigned STROBE_LAT = FILTER_EN ? 3 : 2;
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(STROBE_LAT);

    // Synchronized strobes and data
    logic                     ce_s, we_s, oe_s;
    logic [MC_ADD_WIDTH-1:0]  add_s, add_h;
    logic [MC_DATA_WIDTH-1:0] din_s, din_h;

    mc_bridge_sync_ff #(
        .WIDTH   (3),
        .RST_VAL (3'b111),
        .FILTER  (FILTER_EN),
        .DELAY   (1'b0)
    ) u_sync_strobe (
        .clock (clock),
        .reset (reset),
        .d     ({bus.mc_ce, bus.mc_we, bus.mc_oe}),
        .q     ({ce_s, we_s, oe_s})
    );

    mc_bridge_sync_ff #(
        .WIDTH   (MC_ADD_WIDTH),
        .RST_VAL ('0),
        .FILTER  (1'b0),
        .DELAY   (FILTER_EN)
    ) u_sync_add (
        .clock (clock),
        .reset (reset),
        .d     (bus.mc_add),
        .q     (add_s)
    );

    mc_bridge_sync_ff #(
        .WIDTH   (MC_DATA_WIDTH),
        .RST_VAL ('0),
        .FILTER  (1'b0),
        .DELAY   (FILTER_EN)
    ) u_sync_din (
        .clock (clock),
        .reset (reset),
        .d     (bus.mc_din),
        .q     (din_s)
    );

    // History stage: holds the last sample taken while WE was still low
    always_ff @(posedge clock) begin
        if (reset) begin
            add_h <= '0;
            din_h <= '0;
        end else begin
            add_h <= add_s;
            din_h <= din_s;
        end
    end

    function automatic logic is_internal(input logic [MC_ADD_WIDTH-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    state_t                   state, state_n;
    logic [SETTLE_W-1:0]      settle, settle_n;
    logic                     wr_stb_n, rd_stb_n;
    logic [MC_ADD_WIDTH-1:0]  wr_add_n, rd_add_n;
    logic [MC_DATA_WIDTH-1:0] wr_data_n;
    logic [MC_DATA_WIDTH-1:0] dout_q, dout_n;
    logic                     dout_oe_q, dout_oe_n;
    logic [ERR_WIDTH-1:0]     err_n;
    logic                     err_inc;
    logic                     reg_we;
    logic [MC_DATA_WIDTH-1:0] regs [NUM_REGS];

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WAIT_IDLE;
            settle    <= SETTLE_INIT;
            wr_stb    <= 1'b0;
            wr_add    <= '0;
            wr_data   <= '0;
            rd_stb    <= 1'b0;
            rd_add    <= '0;
            dout_q    <= '0;
            dout_oe_q <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            settle    <= settle_n;
            wr_stb    <= wr_stb_n;
            wr_add    <= wr_add_n;
            wr_data   <= wr_data_n;
            rd_stb    <= rd_stb_n;
            rd_add    <= rd_add_n;
            dout_q    <= dout_n;
            dout_oe_q <= dout_oe_n;
            err_cnt   <= err_n;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n   = state;
        settle_n  = (settle != '0) ? settle - SETTLE_W'(1) : settle;
        wr_stb_n  = 1'b0;
        wr_add_n  = wr_add;
        wr_data_n = wr_data;
        rd_stb_n  = 1'b0;
        rd_add_n  = rd_add;
        dout_n    = dout_q;
        err_inc   = 1'b0;

        case (state)
            // Synchronizers still hold reset values right after reset; wait
            // until they reflect the pins so a transaction in flight is dropped
            WAIT_IDLE: begin
                if (settle == '0 && ce_s) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (!ce_s) begin
                    if (!we_s && !oe_s) begin
                        err_inc = 1'b1;
                        state_n = WAIT_IDLE;
                    end else if (!we_s) begin
                        state_n = WRITE;
                    end else if (!oe_s) begin
                        state_n = RD_LOAD;
                    end
                end
            end
            WRITE: begin
                if (!oe_s) begin
                    err_inc = 1'b1;
                    state_n = WAIT_IDLE;
                end else if (we_s) begin
                    wr_stb_n  = 1'b1;
                    wr_add_n  = add_h;
                    wr_data_n = din_h;
                    state_n   = IDLE;
                end else if (ce_s) begin
                    err_inc = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_LOAD: begin
                if (is_internal(add_s)) begin
                    dout_n = regs[IDX_W'(add_s)];
                end else begin
                    rd_stb_n = 1'b1;
                    rd_add_n = add_s;
                end
                state_n = RD_DRIVE;
            end
            RD_DRIVE: begin
                // rd_stb is high only in the first RD_DRIVE cycle of an external read
                if (rd_stb) begin
                    dout_n = rd_data;
                end
                if (oe_s || ce_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = WAIT_IDLE;
            end
        endcase

        err_n     = (err_inc && err_cnt != '1) ? err_cnt + ERR_WIDTH'(1) : err_cnt;
        dout_oe_n = (state_n == RD_DRIVE);
        reg_we    = wr_stb_n && is_internal(wr_add_n);
    end

    // Register file, updated in the same cycle wr_stb goes high
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (reg_we) begin
            regs[IDX_W'(wr_add_n)] <= wr_data_n;
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_q
            assign reg_q[k*MC_DATA_WIDTH +: MC_DATA_WIDTH] = regs[k];
        end
    endgenerate

    assign bus.mc_dout    = dout_q;
    assign bus.mc_dout_oe = dout_oe_q;

endmodule

// File: tb/tb_mc_bridge.sv
// Directed testbench for mc_bridge: drives the MCU bus pins, checks writes,
// internal/external reads, protocol errors, reset mid-write, WE glitch
// handling and error-counter saturation.
module tb_mc_bridge;
    import mc_bridge_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 6;
    localparam int unsigned NR = 32;
`ifdef MC_BRIDGE_FILTER_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NR*DW-1:0] reg_q;
    logic             wr_stb;
    logic [AW-1:0]    wr_add;
    logic [DW-1:0]    wr_data;
    logic             rd_stb;
    logic [AW-1:0]    rd_add;
    logic [DW-1:0]    rd_data;
    logic [7:0]       err_cnt;

    mc_bridge_if #(.DW(DW), .AW(AW)) bus ();

    mc_bridge #(
        .MC_DATA_WIDTH (DW),
        .MC_ADD_WIDTH  (AW),
        .NUM_REGS      (NR)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .reg_q   (reg_q),
        .wr_stb  (wr_stb),
        .wr_add  (wr_add),
        .wr_data (wr_data),
        .rd_stb  (rd_stb),
        .rd_add  (rd_add),
        .rd_data (rd_data),
        .err_cnt (err_cnt)
    );

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_errors = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            oe_cycles = 0;
    logic [AW-1:0] last_wr_add = '0;
    logic [DW-1:0] last_wr_data = '0;
    logic [NR*DW-1:0] exp_q;

    // Event monitor on the inactive edge
    always @(negedge clock) begin
        if (wr_stb) begin
            wr_cnt++;
            last_wr_add  = wr_add;
            last_wr_data = wr_data;
        end
        if (rd_stb) rd_cnt++;
        if (bus.mc_dout_oe) oe_cycles++;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int we_low);
        bus.mc_add = a;
        bus.mc_din = d;
        bus.mc_ce  = 1'b0;
        step(3 + EXTRA);
        bus.mc_we = 1'b0;
        step(we_low);
        bus.mc_we = 1'b1;
        step(3 + EXTRA);
        bus.mc_ce = 1'b1;
        step(4 + EXTRA);
    endtask

    task automatic err_pulse();
        bus.mc_ce = 1'b0;
        bus.mc_we = 1'b0;
        bus.mc_oe = 1'b0;
        step(3 + EXTRA);
        bus.mc_ce = 1'b1;
        bus.mc_we = 1'b1;
        bus.mc_oe = 1'b1;
        step(4 + EXTRA);
    endtask

    int w0, r0, o0;

    initial begin
        bus.mc_ce  = 1'b1;
        bus.mc_we  = 1'b1;
        bus.mc_oe  = 1'b1;
        bus.mc_add = '0;
        bus.mc_din = '0;
        rd_data    = '0;
        exp_q      = '0;

        // Reset state
        step(3);
        check("rst_reg_q",   reg_q, '0);
        check("rst_dout",    bus.mc_dout, 16'h0000);
        check("rst_dout_oe", bus.mc_dout_oe, 1'b0);
        check("rst_wr_stb",  wr_stb, 1'b0);
        check("rst_rd_stb",  rd_stb, 1'b0);
        check("rst_err_cnt", err_cnt, 8'h00);
        check("rst_wr_add",  wr_add, 6'h00);
        reset = 1'b0;
        step(4 + EXTRA);

        // Test 1: write 0x19 = 0x1234
        w0 = wr_cnt;
        bus_write(REG_PWM_ON, 16'h1234, 6);
        exp_q[415:400] = 16'h1234;
        check("t1_wr_count", wr_cnt - w0, 1);
        check("t1_wr_add",   last_wr_add, 6'h19);
        check("t1_wr_data",  last_wr_data, 16'h1234);
        check("t1_reg_q",    reg_q, exp_q);

        // Test 2: read 0x19 with exact enable timing
        bus.mc_add = 6'h19;
        bus.mc_ce  = 1'b0;
        step(2 + EXTRA);
        bus.mc_oe = 1'b0;
        step(3 + EXTRA);
        check("t2_oe_early", bus.mc_dout_oe, 1'b0);
        step(1);
        check("t2_oe_rise",  bus.mc_dout_oe, 1'b1);
        check("t2_dout",     bus.mc_dout, 16'h1234);
        step(3);
        check("t2_dout_hold", bus.mc_dout, 16'h1234);
        bus.mc_oe = 1'b1;
        step(2 + EXTRA);
        check("t2_oe_hold",  bus.mc_dout_oe, 1'b1);
        step(1);
        check("t2_oe_drop",  bus.mc_dout_oe, 1'b0);
        bus.mc_ce = 1'b1;
        step(4 + EXTRA);

        // Test 3: external read 0x30
        rd_data    = 16'hBEEF;
        bus.mc_add = 6'h30;
        bus.mc_ce  = 1'b0;
        step(2 + EXTRA);
        r0 = rd_cnt;
        bus.mc_oe = 1'b0;
        step(4 + EXTRA);
        check("t3_rd_stb",   rd_stb, 1'b1);
        check("t3_rd_add",   rd_add, 6'h30);
        check("t3_oe",       bus.mc_dout_oe, 1'b1);
        step(1);
        check("t3_dout",     bus.mc_dout, 16'hBEEF);
        check("t3_rd_stb_lo", rd_stb, 1'b0);
        rd_data = 16'h0000;
        step(2);
        check("t3_dout_hold", bus.mc_dout, 16'hBEEF);
        bus.mc_oe = 1'b1;
        bus.mc_ce = 1'b1;
        step(4 + EXTRA);
        check("t3_rd_count", rd_cnt - r0, 1);
        check("t3_oe_off",   bus.mc_dout_oe, 1'b0);
        check("t3_reg_q",    reg_q, exp_q);

        // External-address write: strobe only, no register update
        w0 = wr_cnt;
        bus_write(6'h30, 16'h5555, 6);
        check("ext_wr_count", wr_cnt - w0, 1);
        check("ext_wr_add",   last_wr_add, 6'h30);
        check("ext_reg_q",    reg_q, exp_q);

        // Test 4: WE and OE low together
        w0 = wr_cnt;
        o0 = oe_cycles;
        bus.mc_ce = 1'b0;
        step(2 + EXTRA);
        bus.mc_we = 1'b0;
        bus.mc_oe = 1'b0;
        step(6);
        check("t4_err_cnt", err_cnt, 8'd1);
        bus.mc_we = 1'b1;
        bus.mc_oe = 1'b1;
        step(3);
        bus.mc_we = 1'b0;
        step(6);
        bus.mc_we = 1'b1;
        step(6);
        check("t4_no_wr",      wr_cnt - w0, 0);
        check("t4_no_oe",      oe_cycles - o0, 0);
        check("t4_err_stable", err_cnt, 8'd1);
        bus.mc_ce = 1'b1;
        step(4 + EXTRA);
        bus_write(REG_PWM_OFF, 16'hA5A5, 6);
        exp_q[431:416] = 16'hA5A5;
        check("t4_wr_after", wr_cnt - w0, 1);
        check("t4_reg_q",    reg_q, exp_q);

        // Back-to-back writes with ce held low
        w0 = wr_cnt;
        bus.mc_ce  = 1'b0;
        bus.mc_add = 6'h02;
        bus.mc_din = 16'h0202;
        step(3 + EXTRA);
        bus.mc_we = 1'b0;
        step(4);
        bus.mc_we = 1'b1;
        step(3 + EXTRA);
        bus.mc_add = 6'h03;
        bus.mc_din = 16'h0303;
        step(3 + EXTRA);
        bus.mc_we = 1'b0;
        step(4);
        bus.mc_we = 1'b1;
        step(3 + EXTRA);
        bus.mc_ce = 1'b1;
        step(4 + EXTRA);
        exp_q[47:32] = 16'h0202;
        exp_q[63:48] = 16'h0303;
        check("b2b_wr_count", wr_cnt - w0, 2);
        check("b2b_wr_data",  last_wr_data, 16'h0303);
        check("b2b_reg_q",    reg_q, exp_q);

        // Test 5: reset mid-write, WE rises after release
        bus.mc_add = 6'h05;
        bus.mc_din = 16'hDEAD;
        bus.mc_ce  = 1'b0;
        step(3 + EXTRA);
        bus.mc_we = 1'b0;
        step(4);
        reset = 1'b1;
        step(2);
        check("t5_rst_err", err_cnt, 8'd0);
        reset = 1'b0;
        w0 = wr_cnt;
        step(3);
        bus.mc_we = 1'b1;
        step(6);
        exp_q = '0;
        check("t5_no_commit", wr_cnt - w0, 0);
        check("t5_reg_q",     reg_q, exp_q);
        bus.mc_ce = 1'b1;
        step(4 + EXTRA);
        bus_write(6'h05, 16'hDEAD, 6);
        exp_q[95:80] = 16'hDEAD;
        check("t5_wr_after", wr_cnt - w0, 1);
        check("t5_reg_q2",   reg_q, exp_q);

        // Test 6: one-clock WE glitch
        w0 = wr_cnt;
        bus.mc_add = 6'h07;
        bus.mc_din = 16'h0707;
        bus.mc_ce  = 1'b0;
        step(3 + EXTRA);
        bus.mc_we = 1'b0;
        step(1);
        bus.mc_we = 1'b1;
        step(6);
        bus.mc_ce = 1'b1;
        step(4 + EXTRA);
`ifdef MC_BRIDGE_FILTER_EN
        check("t6_glitch_wr", wr_cnt - w0, 0);
`else
        exp_q[127:112] = 16'h0707;
        check("t6_glitch_wr", wr_cnt - w0, 1);
`endif
        check("t6_reg_q", reg_q, exp_q);

        // Error counter saturation
        for (int i = 0; i < 254; i++) err_pulse();
        check("sat_254", err_cnt, 8'd254);
        err_pulse();
        check("sat_255", err_cnt, 8'd255);
        err_pulse();
        check("sat_hold", err_cnt, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
